// File: rtl/byte_addr_data_mem_if.sv
// Request/response bus for byte_addr_data_mem.
// master: drives req_* (valid, we, addr, size, signed, wdata), receives req_ready and resp_*.
// slave : the memory; drives req_ready, resp_valid, resp_rdata, resp_err.
interface byte_addr_data_mem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_signed, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/byte_addr_data_mem.sv
// Byte-addressable little-endian data memory with a fixed-latency valid/ready
// request port and a one-cycle response pulse.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset (control/response state only)
//   bus   - slave side of byte_addr_data_mem_if (request in, response out)
module byte_addr_data_mem #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    byte_addr_data_mem_if.slave        bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = 2;

    typedef enum logic {IDLE, BUSY} state_e;

    // Array starts at zero; reset never touches it.
    logic [31:0] mem_q [DEPTH_WORDS] = '{default: 32'h0};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ready_q, ready_d;
    logic               resp_valid_q, resp_valid_d;
    logic [31:0]        resp_rdata_q, resp_rdata_d;
    logic               resp_err_q, resp_err_d;
    logic [31:0]        pend_rdata_q, pend_rdata_d;
    logic               pend_err_q, pend_err_d;

    logic [IDX_W-1:0]   idx_c;
    logic [1:0]         lane_c;
    logic               err_c;
    logic [31:0]        rd_word_c;
    logic [7:0]         rd_byte_c;
    logic [15:0]        rd_half_c;
    logic [31:0]        load_c;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic               accept_c;
    logic               write_c;

    // Address decode, fault detection, load extraction and store lane steering.
    always_comb begin
        idx_c  = bus.req_addr[IDX_W+1:2];
        lane_c = bus.req_addr[1:0];

        case (bus.req_size)
            2'b00:   err_c = 1'b0;
            2'b01:   err_c = lane_c[0];
            2'b10:   err_c = |lane_c;
            default: err_c = 1'b1;
        endcase
        if (|bus.req_addr[31:IDX_W+2]) begin
            err_c = 1'b1;
        end

        rd_word_c = mem_q[idx_c];
        rd_byte_c = 8'(rd_word_c >> {lane_c, 3'b000});
        rd_half_c = lane_c[1] ? rd_word_c[31:16] : rd_word_c[15:0];

        case (bus.req_size)
            2'b00:   load_c = {{24{bus.req_signed & rd_byte_c[7]}}, rd_byte_c};
            2'b01:   load_c = {{16{bus.req_signed & rd_half_c[15]}}, rd_half_c};
            default: load_c = rd_word_c;
        endcase

        // Replicate store data across lanes so each enabled lane picks its own copy.
        case (bus.req_size)
            2'b00: begin
                be_c    = 4'b0001 << lane_c;
                wdata_c = {4{bus.req_wdata[7:0]}};
            end
            2'b01: begin
                be_c    = lane_c[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{bus.req_wdata[15:0]}};
            end
            2'b10: begin
                be_c    = 4'b1111;
                wdata_c = bus.req_wdata;
            end
            default: begin
                be_c    = 4'b0000;
                wdata_c = bus.req_wdata;
            end
        endcase

        accept_c = bus.req_valid & ready_q;
        write_c  = accept_c & bus.req_we & ~err_c & ~reset;
    end

    // Store commits at the acceptance edge, byte lanes only.
    always_ff @(posedge clk) begin
        if (write_c) begin
            for (int i = 0; i < 4; i++) begin
                if (be_c[i]) begin
                    mem_q[idx_c][8*i +: 8] <= wdata_c[8*i +: 8];
                end
            end
        end
    end

    // Next-state and response logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ready_d      = 1'b1;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        pend_rdata_d = pend_rdata_q;
        pend_err_d   = pend_err_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    if (LATENCY == 1) begin
                        resp_valid_d = 1'b1;
                        resp_rdata_d = (bus.req_we || err_c) ? 32'h0 : load_c;
                        resp_err_d   = err_c;
                    end else begin
                        // Counter holds the remaining BUSY edges before the response cycle.
                        state_d      = BUSY;
                        cnt_d        = CNT_W'(LATENCY - 1);
                        ready_d      = 1'b0;
                        pend_rdata_d = (bus.req_we || err_c) ? 32'h0 : load_c;
                        pend_err_d   = err_c;
                    end
                end
            end
            BUSY: begin
                ready_d = 1'b0;
                cnt_d   = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d      = IDLE;
                    ready_d      = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = pend_rdata_q;
                    resp_err_d   = pend_err_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_err_q   <= 1'b0;
            pend_rdata_q <= 32'h0;
            pend_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ready_q      <= ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            pend_rdata_q <= pend_rdata_d;
            pend_err_q   <= pend_err_d;
        end
    end

    assign bus.req_ready  = ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_byte_addr_data_mem.sv
// Directed bench for byte_addr_data_mem: one instance with LATENCY=1 and one
// with LATENCY=3, sharing clock and reset.
module tb_byte_addr_data_mem;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   ntests = 0;
    int   nfail  = 0;

    always #5 clk = ~clk;

    byte_addr_data_mem_if b1 ();
    byte_addr_data_mem_if b3 ();

    byte_addr_data_mem #(.DEPTH_WORDS(64), .LATENCY(1)) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    byte_addr_data_mem #(.DEPTH_WORDS(64), .LATENCY(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (b3)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // LATENCY=1: drive at negedge, accept at posedge, check response next negedge.
    task automatic txn1(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        b1.req_valid  = 1'b1;
        b1.req_we     = we;
        b1.req_addr   = addr;
        b1.req_size   = size;
        b1.req_signed = sgn;
        b1.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        chk1 ({tag, ".valid"}, b1.resp_valid, 1'b1);
        chk1 ({tag, ".ready"}, b1.req_ready, 1'b1);
        chk32({tag, ".rdata"}, b1.resp_rdata, exp_rd);
        chk1 ({tag, ".err"},   b1.resp_err, exp_err);
    endtask

    task automatic idle1(input string tag);
        b1.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1 ({tag, ".novalid"}, b1.resp_valid, 1'b0);
        chk32({tag, ".rdata0"},  b1.resp_rdata, 32'h0);
        chk1 ({tag, ".err0"},    b1.resp_err, 1'b0);
    endtask

    // LATENCY=3: two BUSY cycles with junk on the request port, then the response.
    task automatic txn3(input logic we, input logic [31:0] addr, input logic [1:0] size,
                        input logic sgn, input logic [31:0] wdata,
                        input logic [31:0] exp_rd, input logic exp_err, input string tag);
        b3.req_valid  = 1'b1;
        b3.req_we     = we;
        b3.req_addr   = addr;
        b3.req_size   = size;
        b3.req_signed = sgn;
        b3.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        chk1({tag, ".busy1.ready"}, b3.req_ready, 1'b0);
        chk1({tag, ".busy1.valid"}, b3.resp_valid, 1'b0);
        b3.req_valid = 1'b1;
        b3.req_we    = 1'b1;
        b3.req_addr  = 32'h10;
        b3.req_size  = 2'b10;
        b3.req_wdata = 32'h0BAD0BAD;
        @(posedge clk);
        @(negedge clk);
        chk1({tag, ".busy2.ready"}, b3.req_ready, 1'b0);
        chk1({tag, ".busy2.valid"}, b3.resp_valid, 1'b0);
        b3.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1 ({tag, ".valid"}, b3.resp_valid, 1'b1);
        chk1 ({tag, ".ready"}, b3.req_ready, 1'b1);
        chk32({tag, ".rdata"}, b3.resp_rdata, exp_rd);
        chk1 ({tag, ".err"},   b3.resp_err, exp_err);
    endtask

    task automatic idle3(input string tag);
        b3.req_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk1 ({tag, ".novalid"}, b3.resp_valid, 1'b0);
        chk32({tag, ".rdata0"},  b3.resp_rdata, 32'h0);
    endtask

    // Accept a request on dut3, assert reset one cycle later, confirm it is dropped.
    task automatic rst3(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input string tag);
        b3.req_valid  = 1'b1;
        b3.req_we     = we;
        b3.req_addr   = addr;
        b3.req_size   = 2'b10;
        b3.req_signed = 1'b0;
        b3.req_wdata  = wdata;
        @(posedge clk);
        @(negedge clk);
        b3.req_valid = 1'b0;
        chk1({tag, ".pre.ready"}, b3.req_ready, 1'b0);
        reset = 1'b1;
        #1;
        chk1({tag, ".async.ready"}, b3.req_ready, 1'b1);
        chk1({tag, ".async.valid"}, b3.resp_valid, 1'b0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk1({tag, ".dropped"}, b3.resp_valid, 1'b0);
        end
        chk1({tag, ".post.ready"}, b3.req_ready, 1'b1);
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_we = 1'b0; b1.req_addr = 32'h0;
        b1.req_size = 2'b00; b1.req_signed = 1'b0; b1.req_wdata = 32'h0;
        b3.req_valid = 1'b0; b3.req_we = 1'b0; b3.req_addr = 32'h0;
        b3.req_size = 2'b00; b3.req_signed = 1'b0; b3.req_wdata = 32'h0;

        // Reset state
        repeat (2) @(negedge clk);
        chk1 ("rst.l1.ready", b1.req_ready, 1'b1);
        chk1 ("rst.l1.valid", b1.resp_valid, 1'b0);
        chk32("rst.l1.rdata", b1.resp_rdata, 32'h0);
        chk1 ("rst.l1.err",   b1.resp_err, 1'b0);
        chk1 ("rst.l3.ready", b3.req_ready, 1'b1);
        chk1 ("rst.l3.valid", b3.resp_valid, 1'b0);
        reset = 1'b0;
        @(negedge clk);

        // Back-to-back word store then load
        txn1(1'b1, 32'h8, 2'b10, 1'b0, 32'hDEADBEEF, 32'h0,        1'b0, "sw8");
        txn1(1'b0, 32'h8, 2'b10, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, "lw8");
        idle1("l1.gap");

        // Sub-word stores and extending loads
        txn1(1'b1, 32'hA, 2'b00, 1'b0, 32'hFFFFFF7F, 32'h0,        1'b0, "sbA");
        txn1(1'b1, 32'h8, 2'b01, 1'b0, 32'hAAAA1234, 32'h0,        1'b0, "sh8");
        txn1(1'b0, 32'h8, 2'b10, 1'b0, 32'h0,        32'hDE7F1234, 1'b0, "lw8b");
        txn1(1'b0, 32'hB, 2'b00, 1'b1, 32'h0,        32'hFFFFFFDE, 1'b0, "lbB");
        txn1(1'b0, 32'hB, 2'b00, 1'b0, 32'h0,        32'h000000DE, 1'b0, "lbuB");
        txn1(1'b0, 32'hA, 2'b01, 1'b1, 32'h0,        32'hFFFFDE7F, 1'b0, "lhA");
        txn1(1'b0, 32'h8, 2'b00, 1'b1, 32'h0,        32'h00000034, 1'b0, "lb8pos");
        txn1(1'b0, 32'h9, 2'b10, 1'b1, 32'h0,        32'h0,        1'b1, "lw9err");

        // Faulting requests: error, zero data, no write
        txn1(1'b0, 32'h9,   2'b01, 1'b1, 32'h0,        32'h0, 1'b1, "lh9");
        txn1(1'b0, 32'h6,   2'b10, 1'b0, 32'h0,        32'h0, 1'b1, "lw6");
        txn1(1'b1, 32'h8,   2'b11, 1'b0, 32'hFFFFFFFF, 32'h0, 1'b1, "sz11");
        txn1(1'b0, 32'h100, 2'b10, 1'b0, 32'h0,        32'h0, 1'b1, "lw100");
        txn1(1'b1, 32'h100, 2'b10, 1'b0, 32'h11111111, 32'h0, 1'b1, "sw100");
        txn1(1'b1, 32'h108, 2'b10, 1'b0, 32'h22222222, 32'h0, 1'b1, "sw108");
        txn1(1'b1, 32'h9,   2'b01, 1'b0, 32'h0000FFFF, 32'h0, 1'b1, "sh9");
        txn1(1'b0, 32'h8,   2'b10, 1'b0, 32'h0,        32'hDE7F1234, 1'b0, "lw8c");
        txn1(1'b0, 32'h0,   2'b10, 1'b0, 32'h0,        32'h0,        1'b0, "lw0");
        idle1("l1.end");

        // LATENCY=3 timing, ignored inputs during BUSY, accept at end of response
        txn3(1'b1, 32'h10, 2'b10, 1'b0, 32'hCAFEF00D, 32'h0,        1'b0, "l3.sw10");
        txn3(1'b0, 32'h10, 2'b10, 1'b0, 32'h0,        32'hCAFEF00D, 1'b0, "l3.lw10");
        txn3(1'b0, 32'h12, 2'b01, 1'b1, 32'h0,        32'hFFFFCAFE, 1'b0, "l3.lh12");
        txn3(1'b0, 32'h11, 2'b10, 1'b0, 32'h0,        32'h0,        1'b1, "l3.lw11");
        idle3("l3.end");

        // Reset during an in-flight load, then during an in-flight store
        rst3(1'b0, 32'h10, 32'h0, "rst.load");
        txn3(1'b0, 32'h10, 2'b10, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0, "l3.after.lw10");
        idle3("l3.after1");
        rst3(1'b1, 32'h14, 32'h12345678, "rst.store");
        txn3(1'b0, 32'h14, 2'b10, 1'b0, 32'h0, 32'h12345678, 1'b0, "l3.after.lw14");
        idle3("l3.after2");

        // Array contents survive reset
        txn1(1'b0, 32'h8, 2'b10, 1'b0, 32'h0, 32'hDE7F1234, 1'b0, "l1.after.lw8");
        idle1("l1.after");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
